// File: rtl/counter_pkg.sv
// counter_pkg: shared boundary-mode constants and default terminal value for the mod counter.
package counter_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    function automatic int default_max(input int width);
        return (1 << width) - 1;
    endfunction
endpackage

// File: rtl/updown_mod_counter_if.sv
// updown_mod_counter_if: control inputs and count/cascade outputs of one counter stage.
interface updown_mod_counter_if #(parameter int WIDTH = 4);
    logic             en;
    logic             up;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] number;
    logic             tc;
    logic             co;
    logic             ovf;
    modport master (output en, up, sat, load, din, input number, tc, co, ovf);
    modport slave  (input en, up, sat, load, din, output number, tc, co, ovf);
endinterface

// File: rtl/counter_next.sv
// counter_next: next count and boundary flag for an enabled up/down step over 0..MAX.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic [WIDTH-1:0] number,
    input  logic             up,
    input  logic             sat,
    input  logic             en,
    output logic [WIDTH-1:0] next,
    output logic             bnd
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
    logic at_max, at_zero, at_edge;
    logic [WIDTH-1:0] step, wrap_val;
    always_comb begin
        at_max   = number == MAXV;
        at_zero  = number == '0;
        at_edge  = up ? at_max : at_zero;
        step     = up ? number + WIDTH'(1) : number - WIDTH'(1);
        wrap_val = up ? '0 : MAXV;
        bnd      = en & at_edge;
        next     = !en ? number : !at_edge ? step : (sat == MODE_WRAP) ? wrap_val : number;
    end
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: mod-(MAX+1) up/down counter with clamped load, wrap/saturate and cascade carry.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = default_max(WIDTH)
) (
    input logic                  clk,
    input logic                  clr,
    updown_mod_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
    if (MAX < 1 || MAX > (1 << WIDTH) - 1) begin : g_bad_max
        $error("updown_mod_counter: MAX out of range 1..2**WIDTH-1");
    end
    logic [WIDTH-1:0] number_q, number_d, cnt_next;
    logic             ovf_q, ovf_d, bnd;
    counter_next #(.WIDTH(WIDTH), .MAX(MAX)) u_next (
        .number (number_q),
        .up     (bus.up),
        .sat    (bus.sat),
        .en     (bus.en),
        .next   (cnt_next),
        .bnd    (bnd)
    );
    always_comb begin
        number_d = bus.load ? ((bus.din > MAXV) ? MAXV : bus.din) : cnt_next;
        ovf_d    = !bus.load & bnd;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            number_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            number_q <= number_d;
            ovf_q    <= ovf_d;
        end
    end
    assign bus.number = number_q;
    assign bus.ovf    = ovf_q;
    assign bus.tc     = bus.up ? (number_q == MAXV) : (number_q == '0);
    assign bus.co     = bus.en & bus.tc;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed and random checks of a MAX=9 stage plus a two-digit cascade.
module tb_updown_mod_counter;
    import counter_pkg::*;
    localparam int MAXC = 9;
    logic clk = 1'b0;
    logic clr, c_clr;
    int total = 0, bad = 0;
    int m_num = 0, m_ovf = 0;
    updown_mod_counter_if #(.WIDTH(4)) bus ();
    updown_mod_counter_if #(.WIDTH(4)) lo_if ();
    updown_mod_counter_if #(.WIDTH(4)) hi_if ();
    updown_mod_counter #(.WIDTH(4), .MAX(MAXC)) dut (.clk(clk), .clr(clr), .bus(bus));
    updown_mod_counter #(.WIDTH(4), .MAX(MAXC)) u_lo (.clk(clk), .clr(c_clr), .bus(lo_if));
    updown_mod_counter #(.WIDTH(4), .MAX(MAXC)) u_hi (.clk(clk), .clr(c_clr), .bus(hi_if));
    assign hi_if.en   = lo_if.co;
    assign hi_if.up   = lo_if.up;
    assign hi_if.sat  = MODE_WRAP;
    assign hi_if.load = 1'b0;
    assign hi_if.din  = 4'd0;
    always #5 clk = ~clk;

    task automatic drive(input logic c, input logic l, input logic e, input logic u, input logic s, input int d);
        @(negedge clk);
        clr = c; bus.load = l; bus.en = e; bus.up = u; bus.sat = s; bus.din = 4'(d);
        #1;
    endtask

    // Reference: count range 0..MAXC as plain integers; leaving the range is a boundary event.
    task automatic tick();
        int t;
        @(posedge clk);
        if (clr) begin
            m_num = 0; m_ovf = 0;
        end else if (bus.load) begin
            m_num = (int'(bus.din) > MAXC) ? MAXC : int'(bus.din); m_ovf = 0;
        end else if (bus.en) begin
            t = m_num + (bus.up ? 1 : -1);
            if (t < 0 || t > MAXC) begin
                m_ovf = 1;
                if (bus.sat == MODE_WRAP) m_num = (t < 0) ? MAXC : 0;
            end else begin
                m_num = t; m_ovf = 0;
            end
        end else m_ovf = 0;
        #1;
    endtask

    task automatic step(input logic c, input logic l, input logic e, input logic u, input logic s, input int d);
        drive(c, l, e, u, s, d);
        tick();
    endtask

    task automatic test_reset();
        step(1, 1, 1, 0, 0, 5);
        total++; if (bus.number !== 4'd0) begin bad++; $display("FAIL reset_number got=%0d exp=0", bus.number); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf); end
        total++; if (bus.tc !== 1'b1 || bus.co !== 1'b1) begin bad++; $display("FAIL reset_tc_co_down got=%0b%0b exp=11", bus.tc, bus.co); end
        drive(0, 0, 1, 1, 0, 0);
        total++; if (bus.tc !== 1'b0 || bus.co !== 1'b0) begin bad++; $display("FAIL reset_tc_co_up got=%0b%0b exp=00", bus.tc, bus.co); end
    endtask

    task automatic test_wrap_up();
        step(1, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            drive(0, 0, 1, 1, 0, 0);
            total++; if (bus.co !== (k == 10)) begin bad++; $display("FAIL up_co k=%0d got=%0b exp=%0b", k, bus.co, k == 10); end
            tick();
            total++; if (int'(bus.number) !== k % 10) begin bad++; $display("FAIL up_number k=%0d got=%0d exp=%0d", k, bus.number, k % 10); end
            total++; if (bus.ovf !== (k == 10)) begin bad++; $display("FAIL up_ovf k=%0d got=%0b exp=%0b", k, bus.ovf, k == 10); end
        end
    endtask

    task automatic test_wrap_down();
        step(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 1, 0, 0, 0);
            total++; if (int'(bus.number) !== 10 - k) begin bad++; $display("FAIL down_number k=%0d got=%0d exp=%0d", k, bus.number, 10 - k); end
            total++; if (bus.ovf !== (k == 1)) begin bad++; $display("FAIL down_ovf k=%0d got=%0b exp=%0b", k, bus.ovf, k == 1); end
        end
    endtask

    task automatic test_saturate();
        step(0, 1, 0, 1, MODE_SAT, 9);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 1, MODE_SAT, 0);
            total++; if (bus.number !== 4'd9 || bus.ovf !== 1'b1) begin bad++; $display("FAIL sat_hold k=%0d got=%0d/%0b exp=9/1", k, bus.number, bus.ovf); end
        end
        step(0, 0, 1, 0, MODE_SAT, 0);
        total++; if (bus.number !== 4'd8 || bus.ovf !== 1'b0) begin bad++; $display("FAIL sat_release got=%0d/%0b exp=8/0", bus.number, bus.ovf); end
        step(1, 0, 0, 0, MODE_SAT, 0);
        step(0, 0, 1, 0, MODE_SAT, 0);
        total++; if (bus.number !== 4'd0 || bus.ovf !== 1'b1) begin bad++; $display("FAIL sat_zero got=%0d/%0b exp=0/1", bus.number, bus.ovf); end
    endtask

    task automatic test_load();
        step(0, 1, 0, 1, 0, 13);
        total++; if (bus.number !== 4'd9 || bus.ovf !== 1'b0) begin bad++; $display("FAIL load_clamp got=%0d/%0b exp=9/0", bus.number, bus.ovf); end
        step(0, 0, 1, 1, MODE_SAT, 0);
        step(0, 1, 1, 1, MODE_SAT, 13);
        total++; if (bus.number !== 4'd9 || bus.ovf !== 1'b0) begin bad++; $display("FAIL load_at_boundary got=%0d/%0b exp=9/0", bus.number, bus.ovf); end
        step(0, 1, 1, 0, 0, 4);
        total++; if (bus.number !== 4'd4) begin bad++; $display("FAIL load_in_range got=%0d exp=4", bus.number); end
    endtask

    task automatic test_clr_load();
        step(1, 0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0, 7);
        total++; if (bus.number !== 4'd0 || bus.ovf !== 1'b0) begin bad++; $display("FAIL clr_over_load got=%0d/%0b exp=0/0", bus.number, bus.ovf); end
        for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, k[0], k[1], 0);
            total++; if (bus.number !== 4'd3 || bus.ovf !== 1'b0) begin bad++; $display("FAIL hold k=%0d got=%0d/%0b exp=3/0", k, bus.number, bus.ovf); end
        end
    endtask

    task automatic test_random();
        logic etc;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(19) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
                  1'($urandom), 1'($urandom), int'($urandom_range(15)));
            etc = (bus.up && m_num == MAXC) || (!bus.up && m_num == 0);
            total++; if (bus.tc !== etc || bus.co !== (etc & bus.en)) begin bad++; $display("FAIL rand_tc_co i=%0d got=%0b%0b exp=%0b%0b", i, bus.tc, bus.co, etc, etc & bus.en); end
            tick();
            total++; if (int'(bus.number) !== m_num || int'(bus.ovf) !== m_ovf) begin bad++; $display("FAIL rand_state i=%0d got=%0d/%0b exp=%0d/%0d", i, bus.number, bus.ovf, m_num, m_ovf); end
        end
    endtask

    task automatic test_cascade();
        int pulses = 0;
        @(negedge clk); c_clr = 1'b1; lo_if.en = 1'b1;
        @(negedge clk); c_clr = 1'b0;
        total++; if (lo_if.number !== 4'd0 || hi_if.number !== 4'd0) begin bad++; $display("FAIL casc_clear got=%0d%0d exp=00", hi_if.number, lo_if.number); end
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            total++; if (int'(hi_if.number) * 10 + int'(lo_if.number) !== k % 100) begin bad++; $display("FAIL casc_total k=%0d got=%0d%0d exp=%0d", k, hi_if.number, lo_if.number, k % 100); end
            if (hi_if.ovf) pulses++;
        end
        total++; if (hi_if.ovf !== 1'b1 || lo_if.ovf !== 1'b1) begin bad++; $display("FAIL casc_wrap_ovf got=%0b%0b exp=11", hi_if.ovf, lo_if.ovf); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL casc_ovf_count got=%0d exp=1", pulses); end
        lo_if.en = 1'b0;
    endtask

    initial begin
        clr = 1'b1; c_clr = 1'b1;
        bus.en = 1'b0; bus.up = 1'b1; bus.sat = 1'b0; bus.load = 1'b0; bus.din = 4'd0;
        lo_if.en = 1'b0; lo_if.up = 1'b1; lo_if.sat = MODE_WRAP; lo_if.load = 1'b0; lo_if.din = 4'd0;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load();
        test_clr_load();
        test_random();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
